// File: rtl/pause_pkg.sv
// Shared definitions for the pause/dimmer block: FSM states and width helpers.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        FADING = 2'd2,
        DIMMED = 2'd3
    } dim_state_t;

    // Bits needed to hold a dim level in 0..steps (never narrower than 1).
    function automatic int dim_level_width(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

    // Bits needed for a counter running 0..modulus-1 (never narrower than 1).
    function automatic int counter_width(input int modulus);
        return (modulus < 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds timer: a prescaler dividing clk_sys down to one tick per second,
// feeding a seconds counter that saturates at MAX_SECONDS.
module sec_timer
    import pause_pkg::*;
#(
    parameter int TICKS_PER_SEC = 24000000,
    parameter int MAX_SECONDS   = 10
) (
    input  logic                                    clk_sys,
    input  logic                                    reset,
    input  logic                                    clear,
    input  logic                                    enable,
    output logic                                    tick,
    output logic [counter_width(MAX_SECONDS+1)-1:0] seconds
);

    localparam int PW = counter_width(TICKS_PER_SEC);
    localparam int SW = counter_width(MAX_SECONDS + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_MAX  = SW'(MAX_SECONDS);

    logic [PW-1:0] prescaler;

    // Count cycles while enabled; tick pulses in the cycle the seconds count moves.
    always_ff @(posedge clk_sys) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset || clear) begin
            prescaler <= '0;
            seconds   <= '0;
            tick      <= 1'b0;
        end else if (enable) begin
            tick <= 1'b0;
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                tick      <= 1'b1;
                if (seconds != SEC_MAX) begin
                    seconds <= seconds + SW'(1);
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pause_dimmer.sv
// Pause controller with screen dimmer: merges pause sources into a registered
// CPU pause, and after a long enough pause fades the video down in shift steps.
module pause_dimmer
    import pause_pkg::*;
#(
    parameter int RW            = 3,
    parameter int GW            = 3,
    parameter int BW            = 2,
    parameter int NREQ          = 2,
    parameter int TICKS_PER_SEC = 24000000,
    parameter int DIM_SECONDS   = 10,
    parameter int DIM_STEPS     = 2,
    parameter int FADE_TICKS    = 2400000
) (
    input  logic                                    clk_sys,
    input  logic                                    reset,
    input  logic                                    user_button,
    input  logic [NREQ-1:0]                         pause_request,
    input  logic                                    OSD_STATUS,
    input  logic [1:0]                              options,
    input  logic [RW+GW+BW-1:0]                     rgb_in,
    output logic                                    pause_cpu,
    output logic [dim_level_width(DIM_STEPS)-1:0]   dim_level,
    output logic [RW+GW+BW-1:0]                     rgb_out
);

    localparam int DLW = dim_level_width(DIM_STEPS);
    localparam int FW  = counter_width(FADE_TICKS);
    localparam int SW  = counter_width(DIM_SECONDS + 1);

    localparam logic [DLW-1:0] DIM_MAX   = DLW'(DIM_STEPS);
    localparam logic [FW-1:0]  FADE_LAST = FW'(FADE_TICKS - 1);
    localparam logic [SW-1:0]  SEC_LIMIT = SW'(DIM_SECONDS);

    logic                 btn_prev;
    logic                 user_pause;
    dim_state_t           state;
    logic [FW-1:0]        fade_cnt;
    logic                 timer_clear;
    logic                 timer_enable;
    logic                 sec_tick;
    logic [SW-1:0]        seconds;
    logic [RW+GW+BW-1:0]  rgb_shifted;

    // Toggle the user pause flag on each rising edge of the button.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: the edge register loads the live button level during reset,
            // so a button held through reset is not seen as a fresh press.
            btn_prev   <= user_button;
            user_pause <= 1'b0;
        end else begin
            btn_prev <= user_button;
            if (user_button && !btn_prev) begin
                user_pause <= !user_pause;
            end
        end
    end

    // Merge all pause sources into the registered CPU pause.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pause_cpu <= 1'b0;
        end else begin
            pause_cpu <= user_pause | (|pause_request) | (options[0] & OSD_STATUS);
        end
    end

    // The seconds timer only runs in PAUSED and restarts on any abort or resume.
    assign timer_clear  = (state == RUN) || !pause_cpu || !options[1];
    assign timer_enable = (state == PAUSED);

    sec_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .MAX_SECONDS   (DIM_SECONDS)
    ) u_sec_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .tick    (sec_tick),
        .seconds (seconds)
    );

    // Dimmer FSM: resume beats dim-disable, which beats normal progression.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= RUN;
            dim_level <= '0;
            fade_cnt  <= '0;
        end else begin
            // NOTE: fade_cnt gets a default so every path assigns it; it only
            // holds a non-zero value while actively fading.
            fade_cnt <= '0;
            if (state != RUN && !pause_cpu) begin
                state     <= RUN;
                dim_level <= '0;
            end else if (state != RUN && !options[1]) begin
                state     <= PAUSED;
                dim_level <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (pause_cpu) begin
                            state <= PAUSED;
                        end
                    end
                    PAUSED: begin
                        if (sec_tick && seconds == SEC_LIMIT) begin
                            state <= FADING;
                        end
                    end
                    FADING: begin
                        if (fade_cnt == FADE_LAST) begin
                            dim_level <= dim_level + DLW'(1);
                            if (dim_level + DLW'(1) == DIM_MAX) begin
                                state <= DIMMED;
                            end
                        end else begin
                            fade_cnt <= fade_cnt + FW'(1);
                        end
                    end
                    DIMMED: begin
                        dim_level <= DIM_MAX;
                    end
                    default: begin
                        state     <= RUN;
                        dim_level <= '0;
                    end
                endcase
            end
        end
    end

    // Shift each colour channel right by the dim level, zero-filling from the top.
    for (genvar ch = 0; ch < 3; ch++) begin : g_channel
        localparam int W   = (ch == 0) ? RW : (ch == 1) ? GW : BW;
        localparam int LSB = (ch == 0) ? GW + BW : (ch == 1) ? BW : 0;
        assign rgb_shifted[LSB +: W] = rgb_in[LSB +: W] >> dim_level;
    end

    // Register the dimmed video.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= rgb_shifted;
        end
    end

endmodule

// File: tb/tb_pause_dimmer.sv
// Bench for pause_dimmer: a vector table for pause merging, directed sequences
// for fade timing / abort corners, then random stimulus against a timing model.
module tb_pause_dimmer;

    localparam int T_SEC   = 10;
    localparam int D_SEC   = 2;
    localparam int D_STEPS = 2;
    localparam int F_TICKS = 4;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       user_button;
    logic [1:0] pause_request;
    logic       OSD_STATUS;
    logic [1:0] options;
    logic [7:0] rgb_in;
    logic       pause_cpu;
    logic [1:0] dim_level;
    logic [7:0] rgb_out;

    int n_checks = 0;
    int n_fail   = 0;

    pause_dimmer #(
        .RW(3), .GW(3), .BW(2), .NREQ(2),
        .TICKS_PER_SEC(T_SEC), .DIM_SECONDS(D_SEC),
        .DIM_STEPS(D_STEPS), .FADE_TICKS(F_TICKS)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .user_button   (user_button),
        .pause_request (pause_request),
        .OSD_STATUS    (OSD_STATUS),
        .options       (options),
        .rgb_in        (rgb_in),
        .pause_cpu     (pause_cpu),
        .dim_level     (dim_level),
        .rgb_out       (rgb_out)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       btn;
        logic [1:0] req;
        logic       osd;
        logic [1:0] opt;
        logic [7:0] rgb;
        logic       exp_pause;
        logic [1:0] exp_dim;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are stable 1 time unit later.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset(input logic btn);
        reset = 1'b1; user_button = btn; pause_request = 2'b00;
        OSD_STATUS = 1'b0; options = 2'b00; rgb_in = 8'hFF;
        step(); step();
        reset = 1'b0;
    endtask

    // Count edges until dim_level equals target; returns budget on timeout.
    task automatic wait_dim(input logic [1:0] target, input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            step();
            edges++;
            if (dim_level == target) break;
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: dim level is a pure function of how many cycles the
    // dimmer has been counting since its last restart.
    logic m_prev, m_up, m_pause, m_active;
    int   m_dt;
    logic [1:0] m_dim;
    logic [7:0] m_rgb;

    function automatic logic [1:0] level_of(input int dt);
        int start;
        int lvl;
        start = T_SEC * D_SEC + 1;
        if (dt < start + F_TICKS) return 2'd0;
        lvl = (dt - start) / F_TICKS;
        if (lvl > D_STEPS) lvl = D_STEPS;
        return 2'(lvl);
    endfunction

    function automatic logic [7:0] shift_rgb(input logic [7:0] v, input logic [1:0] s);
        int r, g, b;
        r = (int'(v) / 32) >> s;
        g = ((int'(v) / 4) % 8) >> s;
        b = (int'(v) % 4) >> s;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    task automatic model_step();
        logic old_up, old_pause;
        logic [1:0] old_dim;
        if (reset) begin
            m_prev = user_button; m_up = 1'b0; m_pause = 1'b0;
            m_active = 1'b0; m_dt = 0; m_dim = 2'd0; m_rgb = 8'h00;
        end else begin
            old_up = m_up; old_pause = m_pause; old_dim = m_dim;
            if (user_button && !m_prev) m_up = !m_up;
            m_prev = user_button;
            m_pause = old_up | (|pause_request) | (options[0] & OSD_STATUS);
            if (!m_active) begin
                if (old_pause) begin m_active = 1'b1; m_dt = 0; end
            end else if (!old_pause) begin
                m_active = 1'b0; m_dt = 0;
            end else if (!options[1]) begin
                m_dt = 0;
            end else if (m_dt < 100000) begin
                m_dt++;
            end
            m_dim = m_active ? level_of(m_dt) : 2'd0;
            m_rgb = shift_rgb(rgb_in, old_dim);
        end
    endtask

    initial begin
        int e;

        // ---------- reset state ----------
        reset = 1'b1; user_button = 1'b0; pause_request = 2'b11;
        OSD_STATUS = 1'b1; options = 2'b11; rgb_in = 8'hFF;
        step(); step();
        check("reset_pause", 32'(pause_cpu), 0);
        check("reset_dim",   32'(dim_level), 0);
        check("reset_rgb",   32'(rgb_out),   0);
        pause_request = 2'b00; OSD_STATUS = 1'b0; options = 2'b00;
        step();
        reset = 1'b0;

        // ---------- vector table: pause merging ----------
        //            btn  req    osd   opt    rgb    pause dim    rgb_out
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 2'b00, 8'hA5, 1'b0, 2'd0, 8'hA5};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h3C, 1'b0, 2'd0, 8'h3C};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 2'b00, 8'hC3, 1'b1, 2'd0, 8'hC3};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 2'b00, 8'h5A, 1'b1, 2'd0, 8'h5A};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h96, 1'b1, 2'd0, 8'h96};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 2'b00, 8'h69, 1'b0, 2'd0, 8'h69};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 2'b01, 8'hF0, 1'b1, 2'd0, 8'hF0};
        vecs[7]  = '{1'b0, 2'b00, 1'b1, 2'b00, 8'h0F, 1'b0, 2'd0, 8'h0F};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 2'b01, 8'h81, 1'b1, 2'd0, 8'h81};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 2'b00, 8'h7E, 1'b1, 2'd0, 8'h7E};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 2'b00, 8'hE7, 1'b1, 2'd0, 8'hE7};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 2'b00, 8'h18, 1'b1, 2'd0, 8'h18};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 2'b00, 8'h24, 1'b1, 2'd0, 8'h24};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 2'b00, 8'hDB, 1'b1, 2'd0, 8'hDB};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 2'b00, 8'h42, 1'b0, 2'd0, 8'h42};

        for (int i = 0; i < 15; i++) begin
            user_button   = vecs[i].btn;
            pause_request = vecs[i].req;
            OSD_STATUS    = vecs[i].osd;
            options       = vecs[i].opt;
            rgb_in        = vecs[i].rgb;
            step();
            check($sformatf("vec%0d_pause", i), 32'(pause_cpu), 32'(vecs[i].exp_pause));
            check($sformatf("vec%0d_dim",   i), 32'(dim_level), 32'(vecs[i].exp_dim));
            check($sformatf("vec%0d_rgb",   i), 32'(rgb_out),   32'(vecs[i].exp_rgb));
        end

        // ---------- fade timing with a held request ----------
        do_reset(1'b0);
        options = 2'b11; rgb_in = 8'hFF; pause_request = 2'b10;
        wait_dim(2'd1, 60, e);
        check("fade_dim1_latency", 32'(e), 27);
        step();
        check("fade_rgb_dim1", 32'(rgb_out), 32'h6D);
        wait_dim(2'd2, 60, e);
        check("fade_dim2_latency", 32'(e), 3);
        step();
        check("fade_rgb_dim2", 32'(rgb_out), 32'h24);
        repeat (6) step();
        check("dimmed_hold", 32'(dim_level), 2);

        // ---------- dim disable while dimmed ----------
        options = 2'b01;
        step();
        check("dimoff_dim", 32'(dim_level), 0);
        step();
        check("dimoff_rgb", 32'(rgb_out), 32'hFF);
        step();
        check("dimoff_pause", 32'(pause_cpu), 1);
        options = 2'b11;
        wait_dim(2'd1, 60, e);
        check("dimoff_restart_latency", 32'(e), 25);

        // ---------- release request mid-fade, then re-pause ----------
        pause_request = 2'b00;
        step();
        check("release_pause", 32'(pause_cpu), 0);
        check("release_dim_hold", 32'(dim_level), 1);
        step();
        check("release_dim", 32'(dim_level), 0);
        step();
        check("release_rgb", 32'(rgb_out), 32'hFF);
        pause_request = 2'b10;
        wait_dim(2'd1, 60, e);
        check("repause_latency", 32'(e), 27);

        // ---------- reset mid-fade with button held ----------
        reset = 1'b1; user_button = 1'b1; pause_request = 2'b00;
        step();
        check("rstfade_pause", 32'(pause_cpu), 0);
        check("rstfade_dim",   32'(dim_level), 0);
        check("rstfade_rgb",   32'(rgb_out),   0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rstfade_held%0d", i), 32'(pause_cpu), 0);
        end
        user_button = 1'b0;
        repeat (3) step();
        check("rstfade_released", 32'(pause_cpu), 0);
        check("rstfade_dim_after", 32'(dim_level), 0);

        // ---------- random stimulus vs model ----------
        do_reset(1'b0);
        reset = 1'b1; model_step(); reset = 1'b0;
        options = 2'b10;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 59) == 0) user_button = !user_button;
            if ($urandom_range(0, 79) == 0) pause_request[0] = !pause_request[0];
            if ($urandom_range(0, 79) == 0) pause_request[1] = !pause_request[1];
            if ($urandom_range(0, 39) == 0) OSD_STATUS = !OSD_STATUS;
            if ($urandom_range(0, 39) == 0) options[0] = !options[0];
            if ($urandom_range(0, 149) == 0) options[1] = !options[1];
            rgb_in = 8'($urandom);
            model_step();
            step();
            check($sformatf("rnd%0d_pause", c), 32'(pause_cpu), 32'(m_pause));
            check($sformatf("rnd%0d_dim",   c), 32'(dim_level), 32'(m_dim));
            check($sformatf("rnd%0d_rgb",   c), 32'(rgb_out),   32'(m_rgb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
